// File: rtl/sudoku_hex_serializer.sv
// Captures a packed sudoku digit grid on load and streams it one cell per
// valid/ready transfer in row-major order, with row/col/last tags, a blank
// cell counter and a sticky illegal-digit flag.
module sudoku_hex_serializer #(
  parameter int unsigned N  = 9,
  parameter int unsigned DW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [N*N*DW-1:0] hex_in,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_digit,
  output logic [3:0]        out_row,
  output logic [3:0]        out_col,
  output logic              out_last,
  output logic              done,
  output logic [6:0]        blank_cnt,
  output logic              digit_err
);

  localparam int unsigned CELLS = N * N;
  localparam int unsigned GW    = CELLS * DW;
  localparam int unsigned IW    = 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_d;
  logic            accept;
  logic            xfer;
  logic [GW-1:0]   shadow;
  logic [IW-1:0]   idx;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state decode; load is only honoured while idle
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    xfer    = 1'b0;
    case (state)
      S_IDLE: begin
        if (load) begin
          accept  = 1'b1;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        xfer = out_valid & out_ready;
        if (xfer && out_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath: shadow grid shifts down one cell per transfer so the next
  // digit is always at a fixed position
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_digit <= '0;
      out_row   <= '0;
      out_col   <= '0;
      blank_cnt <= '0;
      digit_err <= 1'b0;
      shadow    <= '0;
      idx       <= '0;
    end else begin
      busy <= (state_d != S_IDLE);
      done <= (state_d == S_DONE);
      if (accept) begin
        shadow    <= hex_in;
        out_digit <= hex_in[DW-1:0];
        out_valid <= 1'b1;
        out_last  <= (CELLS == 1);
        out_row   <= '0;
        out_col   <= '0;
        idx       <= '0;
        blank_cnt <= '0;
        digit_err <= 1'b0;
      end else if (xfer) begin
        blank_cnt <= blank_cnt + 7'(out_digit == '0);
        digit_err <= digit_err | (out_digit > DW'(N));
        if (out_last) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          out_digit <= '0;
          out_row   <= '0;
          out_col   <= '0;
          idx       <= '0;
        end else begin
          shadow    <= shadow >> DW;
          out_digit <= shadow[2*DW-1:DW];
          idx       <= idx + IW'(1);
          out_last  <= (idx == IW'(CELLS - 2));
          if (out_col == 4'(N - 1)) begin
            out_col <= '0;
            out_row <= out_row + 4'd1;
          end else begin
            out_col <= out_col + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sudoku_hex_serializer.sv
// Randomized bench for sudoku_hex_serializer against a grid/scoreboard model.
module tb_sudoku_hex_serializer;

  localparam int NC = 81;

  logic         clk;
  logic         rst;
  logic         load;
  logic [323:0] hex_in;
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   out_digit;
  logic [3:0]   out_row;
  logic [3:0]   out_col;
  logic         out_last;
  logic         done;
  logic [6:0]   blank_cnt;
  logic         digit_err;

  int n_checks;
  int n_errors;

  logic [3:0] grid [NC];
  logic [3:0] alt  [NC];

  sudoku_hex_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .hex_in    (hex_in),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_digit (out_digit),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
    .done      (done),
    .blank_cnt (blank_cnt),
    .digit_err (digit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_hex(input bit use_alt);
    for (int i = 0; i < NC; i++)
      hex_in[i*4 +: 4] = use_alt ? alt[i] : grid[i];
  endtask

  task automatic fill_alt();
    for (int i = 0; i < NC; i++) alt[i] = 4'($urandom_range(0, 15));
  endtask

  // Load grid[] and follow the stream cell by cell; optional random
  // backpressure, decoy loads, and a reset when beat rst_at is presented.
  task automatic run_stream(input bit rdy_rand, input bit inject, input int rst_at);
    int k;
    int cyc;
    int blanks;
    int zeros;
    bit err;
    bit any_bad;
    bit xfer;
    k = 0; cyc = 0; blanks = 0; err = 1'b0;
    drive_hex(1'b0);
    load = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    load = 1'b0;
    check("load_valid", out_valid, 1);
    check("load_busy", busy, 1);
    check("load_blank", blank_cnt, 0);
    check("load_err", digit_err, 0);
    while (k < NC && cyc < 4000) begin
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inject && $urandom_range(0, 3) == 0) begin
        fill_alt();
        drive_hex(1'b1);
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      check("valid", out_valid, 1);
      check("digit", out_digit, grid[k]);
      check("row", out_row, k / 9);
      check("col", out_col, k % 9);
      check("last", out_last, (k == NC - 1) ? 1 : 0);
      check("done_early", done, 0);
      if (k == rst_at) rst = 1'b1;
      xfer = out_valid && out_ready;
      @(posedge clk); #1;
      cyc++;
      if (rst) begin
        rst = 1'b0;
        load = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_blank", blank_cnt, 0);
        check("rst_err", digit_err, 0);
        check("rst_done", done, 0);
        @(posedge clk); #1;
        check("rst_done2", done, 0);
        check("rst_valid2", out_valid, 0);
        return;
      end
      if (xfer) begin
        if (grid[k] == 4'd0) blanks++;
        if (grid[k] > 4'd9) err = 1'b1;
        k++;
        check("blank_run", blank_cnt, blanks);
        check("err_run", digit_err, err);
      end
    end
    load = 1'b0;
    if (k < NC) begin
      check("timeout", k, NC);
      return;
    end
    zeros = 0; any_bad = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (grid[i] == 4'd0) zeros++;
      if (grid[i] > 4'd9) any_bad = 1'b1;
    end
    check("done_pulse", done, 1);
    check("done_valid", out_valid, 0);
    check("done_busy", busy, 1);
    check("done_blank", blank_cnt, zeros);
    check("done_err", digit_err, any_bad);
    if (!rdy_rand) check("beat_cycles", cyc, NC);
    if (inject) begin
      fill_alt();
      drive_hex(1'b1);
      load = 1'b1;
    end
    @(posedge clk); #1;
    load = 1'b0;
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_valid", out_valid, 0);
    check("idle_blank", blank_cnt, zeros);
    check("idle_err", digit_err, any_bad);
    @(posedge clk); #1;
    check("idle_valid2", out_valid, 0);
    check("idle_busy2", busy, 0);
  endtask

  task automatic grid_seq();
    for (int i = 0; i < NC; i++) grid[i] = 4'((i % 9) + 1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    load = 1'b0;
    out_ready = 1'b0;
    hex_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy0", busy, 0);
    check("rst_valid0", out_valid, 0);
    check("rst_last0", out_last, 0);
    check("rst_done0", done, 0);
    check("rst_digit0", out_digit, 0);
    check("rst_row0", out_row, 0);
    check("rst_col0", out_col, 0);
    check("rst_blank0", blank_cnt, 0);
    check("rst_err0", digit_err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // sequential digits, ready held high
    grid_seq();
    run_stream(1'b0, 1'b0, -1);

    // all blank
    for (int i = 0; i < NC; i++) grid[i] = 4'd0;
    run_stream(1'b0, 1'b0, -1);

    // sequential digits under random backpressure
    grid_seq();
    run_stream(1'b1, 1'b0, -1);

    // random legal grid with decoy loads mid-stream and in DONE
    for (int i = 0; i < NC; i++) grid[i] = 4'($urandom_range(0, 9));
    run_stream(1'b1, 1'b1, -1);

    // one illegal digit at cell 40
    for (int i = 0; i < NC; i++) grid[i] = 4'($urandom_range(1, 9));
    grid[40] = 4'hC;
    run_stream(1'b1, 1'b0, -1);

    // next load clears the sticky flag
    grid_seq();
    run_stream(1'b0, 1'b0, -1);

    // reset at beat 30, then a fresh stream
    for (int i = 0; i < NC; i++) grid[i] = 4'($urandom_range(0, 9));
    run_stream(1'b1, 1'b0, 30);
    grid_seq();
    run_stream(1'b0, 1'b0, -1);

    // fully random digits including illegal values
    for (int i = 0; i < NC; i++) grid[i] = 4'($urandom_range(0, 15));
    run_stream(1'b1, 1'b1, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
